// File: rtl/intc_hwint_pkg.sv
// Shared definitions for the intc_hwint interrupt controller: register
// offsets, INDEX register layout and the well-known source numbers.
package intc_hwint_pkg;

   // Register selected by Addr[3:2].
   typedef enum logic [1:0] {
      REG_PEND  = 2'd0,
      REG_MASK  = 2'd1,
      REG_MODE  = 2'd2,
      REG_INDEX = 2'd3
   } reg_sel_e;

   // INDEX register: bit 31 flags "some source active", low bits hold its number.
   localparam int INDEX_VALID_BIT = 31;
   localparam int IDX_W           = 3;

   // Fixed wiring of the device interrupt lines onto IRQ_In.
   localparam int SRC_TIMER0 = 0;
   localparam int SRC_TIMER1 = 1;
   localparam int SRC_EXT    = 2;

endpackage

// File: rtl/intc_hwint_prio_enc.sv
// Lowest-index-wins priority encoder for the active interrupt vector.
module intc_hwint_prio_enc
   import intc_hwint_pkg::*;
#(
   parameter int N = 6
) (
   input  logic [N-1:0]     req,
   output logic             valid,
   output logic [IDX_W-1:0] idx
);

   // Scan from the top down so the lowest set bit is the last to write idx.
   always_comb begin
      valid = |req;
      idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/intc_hwint.sv
// Interrupt controller driving CPU HWInt[15:10] as bridge device DEV2.
// Each source is edge (sticky, W1C) or level (transparent) per MODE, and is
// gated onto HWInt by MASK. Build option INTC_SYNC_EN inserts a 2-flop
// synchronizer per IRQ_In bit, needed for the asynchronous external pin.
module intc_hwint
   import intc_hwint_pkg::*;
#(
   parameter int              NSRC     = 6,
   parameter logic [NSRC-1:0] RST_MASK = '0,
   parameter logic [NSRC-1:0] RST_MODE = NSRC'(6'b000100)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NSRC-1:0] IRQ_In,
   input  logic [31:2]     Addr,
   input  logic            WE,
   input  logic [31:0]     Din,
   output logic [31:0]     Dout,
   output logic [NSRC-1:0] HWInt
);

   logic [NSRC-1:0]  s;
   logic [NSRC-1:0]  pend_q, pend_d;
   logic [NSRC-1:0]  mask_q, mask_d;
   logic [NSRC-1:0]  mode_q, mode_d;
   logic [NSRC-1:0]  prev_q, prev_d;
   logic [NSRC-1:0]  pend_clr;
   reg_sel_e         sel;
   logic             irq_valid;
   logic [IDX_W-1:0] irq_idx;
   logic             unused_bits;

   assign sel         = reg_sel_e'(Addr[3:2]);
   assign unused_bits = ^{Addr[31:4], Din[31:NSRC]};

`ifdef INTC_SYNC_EN
   logic [NSRC-1:0] sync1_q, sync1_d;
   logic [NSRC-1:0] sync2_q, sync2_d;

   // Two-stage synchronizer chain in front of the edge/level logic.
   always_comb begin
      sync1_d = IRQ_In;
      sync2_d = sync1_q;
   end

   // Synchronizer flops, cleared with the rest of the block.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign s = sync2_q;
`else
   assign s = IRQ_In;
`endif

   // Next-state for pending, mask, mode and the previous-sample register.
   // An edge-mode set overrides a same-cycle W1C; level bits just follow s.
   always_comb begin
      pend_clr = (WE && sel == REG_PEND) ? Din[NSRC-1:0] : '0;
      pend_d   = pend_q;
      mask_d   = mask_q;
      mode_d   = mode_q;
      prev_d   = s;
      for (int i = 0; i < NSRC; i++) begin
         if (mode_q[i]) begin
            pend_d[i] = (s[i] & ~prev_q[i]) | (pend_q[i] & ~pend_clr[i]);
         end else begin
            pend_d[i] = s[i];
         end
      end
      if (WE && sel == REG_MASK) begin
         mask_d = Din[NSRC-1:0];
      end
      if (WE && sel == REG_MODE) begin
         mode_d = Din[NSRC-1:0];
      end
   end

   // Register state; prev resets to 0 so a line high at release reads as an edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_q <= '0;
         mask_q <= RST_MASK;
         mode_q <= RST_MODE;
         prev_q <= '0;
      end else begin
         pend_q <= pend_d;
         mask_q <= mask_d;
         mode_q <= mode_d;
         prev_q <= prev_d;
      end
   end

   assign HWInt = pend_q & mask_q;

   intc_hwint_prio_enc #(
      .N (NSRC)
   ) u_prio_enc (
      .req   (HWInt),
      .valid (irq_valid),
      .idx   (irq_idx)
   );

   // Read mux; bits not backed by a register read as zero.
   always_comb begin
      Dout = '0;
      case (sel)
         REG_PEND:  Dout[NSRC-1:0] = pend_q;
         REG_MASK:  Dout[NSRC-1:0] = mask_q;
         REG_MODE:  Dout[NSRC-1:0] = mode_q;
         REG_INDEX: begin
            Dout[INDEX_VALID_BIT] = irq_valid;
            Dout[IDX_W-1:0]       = irq_idx;
         end
         default:   Dout = '0;
      endcase
   end

endmodule

// File: tb/tb_intc_hwint.sv
// Self-checking bench for intc_hwint: directed scenarios plus a randomized
// run against a small behavioural model of the register block.
module tb_intc_hwint;
   import intc_hwint_pkg::*;

`ifdef INTC_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic        clk;
   logic        reset;
   logic [5:0]  IRQ_In;
   logic [31:2] Addr;
   logic        WE;
   logic [31:0] Din;
   logic [31:0] Dout;
   logic [5:0]  HWInt;

   logic [31:0] exp_q[$];
   logic [31:0] exp;
   logic [31:0] got;
   int          total;
   int          bad;

   intc_hwint dut (
      .clk    (clk),
      .reset  (reset),
      .IRQ_In (IRQ_In),
      .Addr   (Addr),
      .WE     (WE),
      .Din    (Din),
      .Dout   (Dout),
      .HWInt  (HWInt)
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [1:0] sel, input logic [31:0] d);
      Addr = {28'h0, sel};
      Din  = d;
      WE   = 1'b1;
      @(posedge clk);
      #1;
      WE   = 1'b0;
      Din  = '0;
   endtask

   task automatic rd(input logic [1:0] sel, output logic [31:0] d);
      Addr = {28'h0, sel};
      #1;
      d = Dout;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset  = 1'b1;
      IRQ_In = '0;
      WE     = 1'b0;
      Addr   = '0;
      Din    = '0;
      tick(2);
      exp_q.push_back(32'h0);  // PEND
      exp_q.push_back(32'h0);  // MASK
      exp_q.push_back(32'h4);  // MODE
      exp_q.push_back(32'h0);  // INDEX
      for (int r = 0; r < 4; r++) begin
         rd(2'(r), got);
         exp = exp_q.pop_front();
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL reset_reg%0d got=%h exp=%h", r, got, exp);
         end
      end
      exp_q.push_back(32'h0);
      got = 32'(HWInt);
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL reset_hwint got=%h exp=%h", got, exp);
      end
      reset = 1'b0;
      tick(1);
   endtask

   task automatic test_level();
      wr(REG_MASK, 32'h3F);
      IRQ_In = 6'h01;
      for (int c = 0; c < LAT + 3; c++) begin
         exp_q.push_back(((c + 1) >= LAT && (c + 1) <= LAT + 2) ? 32'h1 : 32'h0);
      end
      for (int c = 0; c < LAT + 3; c++) begin
         tick(1);
         if (c == 2) IRQ_In = 6'h00;
         got = 32'(HWInt);
         exp = exp_q.pop_front();
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL level_hwint cyc%0d got=%h exp=%h", c, got, exp);
         end
         rd(REG_INDEX, got);
         exp = (exp == 32'h1) ? 32'h8000_0000 : 32'h0;
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL level_index cyc%0d got=%h exp=%h", c, got, exp);
         end
      end
      tick(LAT);
   endtask

   task automatic test_edge();
      IRQ_In = 6'h04;
      exp_q.push_back(32'h04);   // PEND after detection
      exp_q.push_back(32'h04);   // HWInt after detection
      exp_q.push_back(32'h04);   // PEND still held later
      exp_q.push_back(32'h00);   // PEND after W1C
      exp_q.push_back(32'h00);   // HWInt after W1C
      tick(1);
      IRQ_In = 6'h00;
      tick(LAT - 1);
      rd(REG_PEND, got);
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL edge_pend got=%h exp=%h", got, exp); end
      got = 32'(HWInt);
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL edge_hwint got=%h exp=%h", got, exp); end
      tick(3);
      rd(REG_PEND, got);
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL edge_hold got=%h exp=%h", got, exp); end
      wr(REG_PEND, 32'h04);
      rd(REG_PEND, got);
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL edge_clr_pend got=%h exp=%h", got, exp); end
      got = 32'(HWInt);
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL edge_clr_hwint got=%h exp=%h", got, exp); end
   endtask

   task automatic test_collision();
      // Arm a pending bit and let the line return low.
      IRQ_In = 6'h04;
      tick(1);
      IRQ_In = 6'h00;
      tick(LAT);
      // New rising edge lands on the same clock as the W1C.
      IRQ_In = 6'h04;
      tick(LAT - 1);
      exp_q.push_back(32'h04);
      wr(REG_PEND, 32'h04);
      rd(REG_PEND, got);
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL collide_set_wins got=%h exp=%h", got, exp); end
      // Line stays high: clear must stick, no fresh set.
      exp_q.push_back(32'h00);
      wr(REG_PEND, 32'h04);
      tick(3);
      rd(REG_PEND, got);
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL held_high_no_reset got=%h exp=%h", got, exp); end
      // Low then high again re-arms.
      exp_q.push_back(32'h04);
      IRQ_In = 6'h00;
      tick(LAT);
      IRQ_In = 6'h04;
      tick(LAT);
      rd(REG_PEND, got);
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL rearm_after_low got=%h exp=%h", got, exp); end
      IRQ_In = 6'h00;
      tick(LAT + 1);
      wr(REG_PEND, 32'h04);
   endtask

   task automatic test_mask();
      wr(REG_MASK, 32'h00);
      exp_q.push_back(32'h00);   // HWInt while masked
      exp_q.push_back(32'h04);   // PEND still records
      exp_q.push_back(32'h04);   // HWInt after unmask
      IRQ_In = 6'h04;
      tick(1);
      IRQ_In = 6'h00;
      tick(LAT - 1);
      got = 32'(HWInt);
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL mask_hwint got=%h exp=%h", got, exp); end
      rd(REG_PEND, got);
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL mask_pend got=%h exp=%h", got, exp); end
      wr(REG_MASK, 32'h04);
      got = 32'(HWInt);
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL unmask_hwint got=%h exp=%h", got, exp); end
      wr(REG_PEND, 32'h04);
      wr(REG_MASK, 32'h3F);
   endtask

   task automatic test_priority();
      wr(REG_MODE, 32'h06);
      exp_q.push_back(32'h06);
      exp_q.push_back(32'h8000_0001);
      exp_q.push_back(32'h8000_0002);
      exp_q.push_back(32'h0);
      IRQ_In = 6'h06;
      tick(1);
      IRQ_In = 6'h00;
      tick(LAT - 1);
      got = 32'(HWInt);
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL prio_hwint got=%h exp=%h", got, exp); end
      rd(REG_INDEX, got);
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL prio_index_both got=%h exp=%h", got, exp); end
      wr(REG_MODE, 32'h04);
      tick(1);
      rd(REG_INDEX, got);
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL prio_index_src2 got=%h exp=%h", got, exp); end
      wr(REG_PEND, 32'h04);
      rd(REG_INDEX, got);
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL prio_index_none got=%h exp=%h", got, exp); end
   endtask

   task automatic test_mode_switch();
      exp_q.push_back(32'h01);   // level-mode pending
      exp_q.push_back(32'h01);   // sticky after switch to edge and input low
      exp_q.push_back(32'h00);   // W1C now works
      IRQ_In = 6'h01;
      tick(LAT);
      rd(REG_PEND, got);
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL mode_level_pend got=%h exp=%h", got, exp); end
      wr(REG_MODE, 32'h05);
      IRQ_In = 6'h00;
      tick(LAT + 1);
      rd(REG_PEND, got);
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL mode_sticky got=%h exp=%h", got, exp); end
      wr(REG_PEND, 32'h01);
      rd(REG_PEND, got);
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL mode_w1c got=%h exp=%h", got, exp); end
      wr(REG_MODE, 32'h04);
   endtask

   task automatic test_async_reset();
      IRQ_In = 6'h04;
      tick(1);
      IRQ_In = 6'h00;
      tick(LAT - 1);
      exp_q.push_back(32'h04);   // pending before reset
      exp_q.push_back(32'h00);   // HWInt right after reset asserts
      exp_q.push_back(32'h00);   // PEND
      exp_q.push_back(32'h00);   // MASK
      exp_q.push_back(32'h04);   // MODE
      exp_q.push_back(32'h00);   // PEND before first post-release edge(s)
      exp_q.push_back(32'h04);   // PEND once the held line is taken as an edge
      got = 32'(HWInt);
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL areset_pre got=%h exp=%h", got, exp); end
      #2;
      reset = 1'b1;
      #1;
      got = 32'(HWInt);
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL areset_hwint got=%h exp=%h", got, exp); end
      for (int r = 0; r < 3; r++) begin
         rd(2'(r), got);
         exp = exp_q.pop_front();
         total++;
         if (got !== exp) begin bad++; $display("FAIL areset_reg%0d got=%h exp=%h", r, got, exp); end
      end
      IRQ_In = 6'h04;
      #1;
      reset = 1'b0;
      tick(LAT - 1);
      rd(REG_PEND, got);
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL release_early got=%h exp=%h", got, exp); end
      tick(1);
      rd(REG_PEND, got);
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL release_edge got=%h exp=%h", got, exp); end
   endtask

   task automatic test_random();
      logic [5:0]  m_pend, m_mask, m_mode, m_prev, m_s1, m_s2, s_now, nxt, clr, hw, irq;
      logic        do_wr;
      logic [1:0]  sel;
      logic [31:0] d;
      logic [31:0] idx_exp;
      IRQ_In = '0;
      reset  = 1'b1;
      tick(1);
      reset  = 1'b0;
      m_pend = '0; m_mask = '0; m_mode = 6'h04; m_prev = '0; m_s1 = '0; m_s2 = '0;
      for (int n = 0; n < 300; n++) begin
         irq   = 6'($urandom_range(0, 63));
         do_wr = ($urandom_range(0, 3) == 0);
         sel   = 2'($urandom_range(0, 3));
         d     = $urandom;
`ifdef INTC_SYNC_EN
         s_now = m_s2;
`else
         s_now = irq;
`endif
         clr = (do_wr && sel == REG_PEND) ? d[5:0] : 6'h0;
         for (int i = 0; i < 6; i++) begin
            nxt[i] = m_mode[i] ? ((s_now[i] & ~m_prev[i]) | (m_pend[i] & ~clr[i])) : s_now[i];
         end
         if (do_wr && sel == REG_MASK) m_mask = d[5:0];
         if (do_wr && sel == REG_MODE) m_mode = d[5:0];
         m_prev = s_now;
         m_s2   = m_s1;
         m_s1   = irq;
         m_pend = nxt;
         exp_q.push_back({20'h0, m_pend, m_pend & m_mask});
         IRQ_In = irq;
         Addr   = {28'h0, sel};
         Din    = d;
         WE     = do_wr;
         tick(1);
         WE     = 1'b0;
         exp = exp_q.pop_front();
         got = 32'(HWInt);
         total++;
         if (got !== {26'h0, exp[5:0]}) begin
            bad++;
            $display("FAIL rand_hwint n=%0d got=%h exp=%h", n, got, exp[5:0]);
         end
         rd(REG_PEND, got);
         total++;
         if (got !== {26'h0, exp[11:6]}) begin
            bad++;
            $display("FAIL rand_pend n=%0d got=%h exp=%h", n, got, exp[11:6]);
         end
         hw      = exp[5:0];
         idx_exp = '0;
         for (int i = 5; i >= 0; i--) begin
            if (hw[i]) idx_exp = 32'h8000_0000 | 32'(i);
         end
         rd(REG_INDEX, got);
         total++;
         if (got !== idx_exp) begin
            bad++;
            $display("FAIL rand_index n=%0d got=%h exp=%h", n, got, idx_exp);
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_level();
      test_edge();
      test_collision();
      test_mask();
      test_priority();
      test_mode_switch();
      test_async_reset();
      test_random();
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/intc_hwint.md
Name: intc_hwint

Overview:
- Interrupt controller that collects device interrupt lines (Timer0 IRQ, Timer1 IRQ, external `interrupt` pin, spares) and drives the CPU's HWInt[15:10] input, which the top level currently ties to zero.
- Exposes pending, mask, mode and encoded-index registers to the CPU as a bridge-mapped device (DEV2).
- Converts edge or level sources into sticky or transparent pending bits, with per-source masking.

Parameters:
- NSRC, 6, number of interrupt sources; fixed to the width of HWInt; legal range 1..6.
- RST_MASK, 6'b000000, mask register value after reset.
- RST_MODE, 6'b000100, mode register value after reset; 1 = edge, 0 = level; source 2 (external pin) is edge by default.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- IRQ_In  in  NSRC  raw interrupt requests; bit0 = Timer0, bit1 = Timer1, bit2 = external interrupt, bits 3..5 spare.
- Addr  in  30  bridge word address (DEV_Addr[31:2]); only bits [3:2] are decoded.
- WE  in  1  bridge write enable for this device.
- Din  in  32  bridge write data.
- Dout  out  32  read data; combinational from Addr[3:2].
- HWInt  out  NSRC  pending & mask; goes to CPU HWInt[15:10].

Behaviour:
- Register map, selected by Addr[3:2]:
  - 0 PEND: read returns pending bits; writing 1 to a bit clears it (edge-mode bits only).
  - 1 MASK: read/write.
  - 2 MODE: read/write.
  - 3 INDEX: read only. Bit31 = any HWInt bit set; bits[2:0] = lowest-numbered set HWInt bit; all other bits 0. Writes are ignored.
- Unused Dout bits read 0.
- Reset, asynchronous: PEND=0, MASK=RST_MASK, MODE=RST_MODE, prev=0. HWInt=0 and Dout is determined by the reset register state.
- Sampling:
  - s = IRQ_In (or the synchronized value, see optional feature).
  - prev <= s every cycle.
- Edge mode (MODE[i]=1):
  - PEND[i] sets on the clock edge where s[i]=1 and prev[i]=0.
  - PEND[i] then holds until cleared by software.
- Level mode (MODE[i]=0):
  - PEND[i] <= s[i] every cycle.
  - W1C writes have no effect.
- Simultaneous set and W1C on the same bit in the same cycle: the set wins and PEND stays 1.
- A held-high edge source creates no further set after a clear until it goes low and then high again.
- Switching MODE from level to edge takes effect next cycle. PEND keeps its current value and becomes sticky.
- A MASK write takes effect on HWInt the cycle after the write edge. PEND is unaffected by MASK, so masked events are still recorded.
- HWInt = PEND & MASK. It is combinational from registers, so there is no glitch from IRQ_In.
- Latency:
  - IRQ_In rising before clock edge k gives HWInt high after edge k (1 cycle).
  - With INTC_SYNC_EN, this becomes after edge k+2.
- Writes complete in one cycle; there is no handshake or wait state.
- Reset asserted mid-operation clears everything immediately. An input held high through reset release counts as an edge on the first post-reset clock, because prev=0.

Optional Feature:
- Macro: INTC_SYNC_EN.
- Defined: each IRQ_In bit passes through a 2-flop synchronizer (reset to 0) before s. This adds 2 cycles of latency and is required for the asynchronous external pin.
- Undefined: s = IRQ_In directly, for single-clock-domain sources only.

Decomposition:
- Shared package: register offset constants, the INDEX valid-bit position (31), and the source-index constants (TIMER0=0, TIMER1=1, EXT=2).
- One natural sub-module: intc_prio_enc, a combinational lowest-index priority encoder producing valid plus a 3-bit index.
- The bridge gains DEV2 decode; that change is outside this block.

Test Plan:
- Reset, then MASK=6'h3F, level source 0: IRQ_In[0] high for 3 cycles, then low → HWInt[0] high for exactly 3 cycles, each delayed 1 cycle; INDEX reads 0x80000000 while high.
- Edge source 2: 1-cycle pulse on IRQ_In[2] → PEND=6'h04 held; write PEND=6'h04 → cleared next cycle; HWInt[2] follows.
- Set/clear collision: write W1C to bit 2 on the same edge that a new rising edge arrives → PEND[2] stays 1.
- Masking: MASK=0, pulse edge source 2 → HWInt=0 and PEND=6'h04; write MASK=6'h04 → HWInt=6'h04 next cycle.
- Priority: sources 1 and 2 pending and unmasked → INDEX=0x80000001; clear source 1 (switch it to level mode and drop the input) → INDEX=0x80000002.
- Async reset mid-pending: assert reset between clock edges → HWInt=0 immediately. With INTC_SYNC_EN, an edge then takes 3 edges from input to HWInt.
